pwm_phase_monitor: RTL and testbench
====================================

# pwm_phase_monitor

Read-back monitor for one BLDC half-bridge. It samples the high-side and low-side gate signals that the phase driver produces, decodes them back into measured high time and PWM period, and tracks the minimum dead time. It flags shoot-through, dead-time violations and static or high-impedance phases. One instance sits beside each phase driver in the motor FPGA. Its outputs feed the status registers and the motor fault latch.

## Interface

Parameters:
- COUNTER_WIDTH, 10, width of measured high-time and period outputs.
- DEAD_WIDTH, 4, width of the dead-time counter and output (saturating).
- MIN_DEAD_TIME, 2, minimum legal gap in clk cycles between one FET turning off and the other turning on.
- TIMEOUT_CYCLES, 2048, cycles with no high-side rising edge before the phase is declared static.

Ports:
- clk  in  1  system clock, same domain as the phase driver.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- pwm_high  in  1  high-side gate signal under observation.
- pwm_low  in  1  low-side gate signal under observation.
- clear_fault  in  1  single-cycle pulse that clears the sticky fault flags.
- duty_cycle  out  COUNTER_WIDTH  high-side on-time of the last complete period, in cycles.
- period  out  COUNTER_WIDTH  cycles between the last two high-side rising edges (saturating).
- duty_valid  out  1  one-cycle strobe when duty_cycle and period update.
- dead_time_min  out  DEAD_WIDTH  smallest gap seen since reset or clear_fault.
- fault_shoot  out  1  sticky: both gates high in the same sampled cycle.
- fault_dead  out  1  sticky: a gap shorter than MIN_DEAD_TIME was seen.
- phase_static  out  1  no high-side edge within TIMEOUT_CYCLES.
- phase_high_z  out  1  phase_static is set and both gates are low.

## Operation

- Inputs pass through a 2-flop synchronizer and then an edge-detect register. All decoding uses the synchronized values sh and sl.
- FSM states and transitions:
  - IDLE: the reset state. It moves to HIGH on sh rising and to LOW on sl rising.
  - HIGH: moves to GAP_HL when sh falls.
  - GAP_HL: moves to LOW on sl rising, or to HIGH on sh rising (gap not checked).
  - LOW: moves to GAP_LH when sl falls.
  - GAP_LH: moves to HIGH on sh rising, or to LOW on sl rising (gap not checked).
- Gap counter:
  - Clears on entry to either GAP state and increments each cycle, saturating at 2^DEAD_WIDTH-1.
  - On the GAP_HL→LOW or GAP_LH→HIGH transition, it is compared with MIN_DEAD_TIME. If smaller, fault_dead is set. dead_time_min takes the lower of its current value and the gap count.
- Shoot-through: any cycle with sh=1 and sl=1 sets fault_shoot. The FSM goes to IDLE and the in-progress period is discarded (no duty_valid).
- High-time counter: counts cycles with sh=1 since the last sh rising edge.
- Period counter: counts cycles since the last sh rising edge, saturating at all-ones.
- On each sh rising edge with a prior edge recorded:
  - duty_cycle ← high count and period ← period count; duty_valid pulses.
  - Both counters restart at 1.
  - The first edge after reset, or after a discarded period, only arms the counters.
- Timeout timer:
  - Internal, clog2(TIMEOUT_CYCLES)+1 bits; it clears on every sh rising edge.
  - When it reaches TIMEOUT_CYCLES, phase_static is set and duty_valid pulses. duty_cycle becomes all-ones if sh=1 and 0 otherwise, and period becomes all-ones.
  - The timer then holds. phase_static clears on the next sh rising edge.
- phase_high_z = phase_static & ~sh & ~sl, registered.
- clear_fault clears fault_shoot and fault_dead and sets dead_time_min to all-ones. If a fault condition occurs in the same cycle as clear_fault, the fault wins.

## Timing

- Reset values: duty_cycle 0, period 0, duty_valid 0, dead_time_min all-ones, all flags 0, FSM IDLE, counters 0.
- Input-to-decode latency is 3 clk: 2 synchronizer stages plus the edge register. All outputs are registered.
- duty_valid asserts 4 clk after the raw pwm_high rising edge, for exactly one cycle.
- fault_shoot and fault_dead assert on the cycle after detection in the synchronized domain and stay high until clear_fault.
- Asserting rst_n mid-period aborts the period; the first edge after release only arms the counters.

## Structure

- Shared motor package holds:
  - the FSM state enum (IDLE, HIGH, GAP_HL, LOW, GAP_LH);
  - the default COUNTER_WIDTH and MIN_DEAD_TIME, shared with the phase driver so that both ends agree.
- One sub-module is natural: pwm_sync_edge, a 2-flop synchronizer plus rise/fall detect, instantiated once per gate input.

## Test plan

- Driver pattern with duty 512, dead time 2, period 1023 → after the arming edge, duty_valid every 1023 cycles with duty_cycle=510, period=1023, dead_time_min=2, no faults.
- Same pattern with the low-side turn-on moved 1 cycle earlier (gap 1) → fault_dead=1, dead_time_min=1. Measurements continue; after clear_fault, fault_dead=0 and dead_time_min=2 after the next period.
- Force pwm_high=pwm_low=1 for 1 cycle → fault_shoot=1, no duty_valid for the broken period, normal strobes resume after the second rising edge.
- Hold pwm_low=1, pwm_high=0 for 3000 cycles → one duty_valid at timeout with duty_cycle=0 and period=1023, phase_static=1, phase_high_z=0.
- Both inputs low for 3000 cycles → phase_static=1, phase_high_z=1. The next pwm_high pulse clears both.
- Assert rst_n low mid-period, then release → outputs at reset values, first strobe only after two further rising edges.

Source files
------------

// File: rtl/pwm_phase_monitor_pkg.sv
// ----------------------------------------------------------------------------
// pwm_phase_monitor_pkg: shared motor constants and gate-decode state enum. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pwm_phase_monitor_pkg;

  // Shared with the phase driver so both ends agree on widths and dead time
  localparam int DEF_COUNTER_WIDTH = 10;
  localparam int DEF_MIN_DEAD_TIME = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HIGH   = 3'd1,
    ST_GAP_HL = 3'd2,
    ST_LOW    = 3'd3,
    ST_GAP_LH = 3'd4
  } phase_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_sync_edge.sv
// ----------------------------------------------------------------------------
// pwm_sync_edge: 2-flop synchronizer followed by a registered rise/fall detect. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sig,
  output logic rise,
  output logic fall
);

  logic [1:0] r_meta;

  // sig, rise and fall leave the edge register together, aligned to the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 2'b00;
      sig    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_meta <= {r_meta[0], din};
      sig    <= r_meta[1];
      rise   <= r_meta[1] & ~sig;
      fall   <= ~r_meta[1] & sig;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_phase_monitor.sv
// ----------------------------------------------------------------------------
// pwm_phase_monitor: half-bridge gate read-back, duty/period decode, dead-time and fault flags. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pwm_phase_monitor
  import pwm_phase_monitor_pkg::*;
#(
  parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
  parameter int DEAD_WIDTH     = 4,
  parameter int MIN_DEAD_TIME  = DEF_MIN_DEAD_TIME,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pwm_high,
  input  logic                     pwm_low,
  input  logic                     clear_fault,
  output logic [COUNTER_WIDTH-1:0] duty_cycle,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic                     duty_valid,
  output logic [DEAD_WIDTH-1:0]    dead_time_min,
  output logic                     fault_shoot,
  output logic                     fault_dead,
  output logic                     phase_static,
  output logic                     phase_high_z
);

  localparam int                     TW         = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [COUNTER_WIDTH-1:0] C_CNT_MAX  = '1;
  localparam logic [DEAD_WIDTH-1:0]  C_DEAD_MAX = '1;
  localparam logic [DEAD_WIDTH-1:0]  C_MIN_DEAD = DEAD_WIDTH'(MIN_DEAD_TIME);
  localparam logic [TW-1:0]          C_TIMEOUT  = TW'(TIMEOUT_CYCLES);

  logic sh, sh_rise, sh_fall;
  logic sl, sl_rise, sl_fall;

  pwm_sync_edge u_sync_high (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pwm_high),
    .sig  (sh),
    .rise (sh_rise),
    .fall (sh_fall)
  );

  pwm_sync_edge u_sync_low (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pwm_low),
    .sig  (sl),
    .rise (sl_rise),
    .fall (sl_fall)
  );

  phase_state_t              r_state, w_state_nxt;
  logic                      w_shoot, w_gap_check, w_in_gap, r_armed;
  logic [DEAD_WIDTH-1:0]     r_gap, w_gap_inc, w_gap_now;
  logic [COUNTER_WIDTH-1:0]  r_high, r_per, w_high_inc, w_per_inc;
  logic [TW-1:0]             r_timer, w_timer_inc;

  assign w_shoot     = sh & sl;
  assign w_in_gap    = (r_state == ST_GAP_HL) || (r_state == ST_GAP_LH);
  assign w_gap_inc   = (r_gap == C_DEAD_MAX) ? r_gap : r_gap + 1'b1;
  // Gap length includes the cycle in which the opposite gate turns on
  assign w_gap_now   = w_in_gap ? w_gap_inc : '0;
  assign w_high_inc  = (r_high == C_CNT_MAX) ? r_high : r_high + COUNTER_WIDTH'(sh);
  assign w_per_inc   = (r_per == C_CNT_MAX) ? r_per : r_per + 1'b1;
  assign w_timer_inc = r_timer + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_check = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sh_rise)      w_state_nxt = ST_HIGH;
        else if (sl_rise) w_state_nxt = ST_LOW;
      end
      ST_HIGH: begin
        // Hand-over in a single cycle is a zero-length gap
        if (sh_fall) begin
          w_state_nxt = sl_rise ? ST_LOW : ST_GAP_HL;
          w_gap_check = sl_rise;
        end
      end
      ST_GAP_HL: begin
        if (sl_rise) begin
          w_state_nxt = ST_LOW;
          w_gap_check = 1'b1;
        end else if (sh_rise) begin
          w_state_nxt = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (sl_fall) begin
          w_state_nxt = sh_rise ? ST_HIGH : ST_GAP_LH;
          w_gap_check = sh_rise;
        end
      end
      ST_GAP_LH: begin
        if (sh_rise) begin
          w_state_nxt = ST_HIGH;
          w_gap_check = 1'b1;
        end else if (sl_rise) begin
          w_state_nxt = ST_LOW;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_shoot) begin
      w_state_nxt = ST_IDLE;
      w_gap_check = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap         <= '0;
      r_high        <= '0;
      r_per         <= '0;
      r_timer       <= '0;
      r_armed       <= 1'b0;
      duty_cycle    <= '0;
      period        <= '0;
      duty_valid    <= 1'b0;
      dead_time_min <= C_DEAD_MAX;
      fault_shoot   <= 1'b0;
      fault_dead    <= 1'b0;
      phase_static  <= 1'b0;
      phase_high_z  <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      r_gap      <= (w_in_gap && (w_state_nxt == r_state)) ? w_gap_inc : '0;

      // A fault seen in the clearing cycle takes precedence over the clear
      if (w_shoot)          fault_shoot <= 1'b1;
      else if (clear_fault) fault_shoot <= 1'b0;

      if (w_gap_check && (w_gap_now < C_MIN_DEAD)) fault_dead <= 1'b1;
      else if (clear_fault)                        fault_dead <= 1'b0;

      if (w_gap_check && (clear_fault || (w_gap_now < dead_time_min)))
        dead_time_min <= w_gap_now;
      else if (clear_fault)
        dead_time_min <= C_DEAD_MAX;

      if (sh_rise) begin
        if (r_armed && !w_shoot) begin
          duty_cycle <= r_high;
          period     <= r_per;
          duty_valid <= 1'b1;
        end
        r_high       <= COUNTER_WIDTH'(1);
        r_per        <= COUNTER_WIDTH'(1);
        r_armed      <= ~w_shoot;
        r_timer      <= '0;
        phase_static <= 1'b0;
      end else begin
        r_high <= w_high_inc;
        r_per  <= w_per_inc;
        if (w_shoot) r_armed <= 1'b0;
        if (r_timer != C_TIMEOUT) begin
          r_timer <= w_timer_inc;
          if (w_timer_inc == C_TIMEOUT) begin
            phase_static <= 1'b1;
            duty_valid   <= 1'b1;
            duty_cycle   <= {COUNTER_WIDTH{sh}};
            period       <= C_CNT_MAX;
          end
        end
      end

      phase_high_z <= phase_static & ~sh & ~sl;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_phase_monitor.sv
// ----------------------------------------------------------------------------
// tb_pwm_phase_monitor: directed vector table plus timeout/reset sequences. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pwm_phase_monitor;

  logic       clk;
  logic       rst_n;
  logic       pwm_high;
  logic       pwm_low;
  logic       clear_fault;
  logic [9:0] duty_cycle;
  logic [9:0] period;
  logic       duty_valid;
  logic [3:0] dead_time_min;
  logic       fault_shoot;
  logic       fault_dead;
  logic       phase_static;
  logic       phase_high_z;

  pwm_phase_monitor #(
    .COUNTER_WIDTH (10),
    .DEAD_WIDTH    (4),
    .MIN_DEAD_TIME (2),
    .TIMEOUT_CYCLES(2048)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_high     (pwm_high),
    .pwm_low      (pwm_low),
    .clear_fault  (clear_fault),
    .duty_cycle   (duty_cycle),
    .period       (period),
    .duty_valid   (duty_valid),
    .dead_time_min(dead_time_min),
    .fault_shoot  (fault_shoot),
    .fault_dead   (fault_dead),
    .phase_static (phase_static),
    .phase_high_z (phase_high_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int g1;
    int lo;
    int g2;
    int nper;
    int shoot_at;
    bit clr;
    int exp_strobes;
    int exp_duty;
    int exp_period;
    int exp_dmin;
    int exp_fdead;
    int exp_fshoot;
  } vec_t;

  vec_t vecs[5];
  int   n_checks  = 0;
  int   n_passed  = 0;
  int   n_strobes = 0;
  int   last_duty = -1;
  int   last_period = -1;

  always @(negedge clk) begin
    if (rst_n && duty_valid) begin
      n_strobes   = n_strobes + 1;
      last_duty   = int'(duty_cycle);
      last_period = int'(period);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act == exp) n_passed = n_passed + 1;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc(input logic h, input logic l);
    pwm_high = h;
    pwm_low  = l;
    @(posedge clk);
    #1;
    clear_fault = 1'b0;
  endtask

  task automatic run_period(input int hi, input int g1, input int lo, input int g2, input int shoot_at);
    for (int i = 0; i < hi; i++) cyc(1'b1, (i == shoot_at) ? 1'b1 : 1'b0);
    for (int i = 0; i < g1; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < lo; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < g2; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_duty"},   int'(duty_cycle),    0);
    chk({tag, "_period"}, int'(period),        0);
    chk({tag, "_dv"},     int'(duty_valid),    0);
    chk({tag, "_dmin"},   int'(dead_time_min), 15);
    chk({tag, "_fshoot"}, int'(fault_shoot),   0);
    chk({tag, "_fdead"},  int'(fault_dead),    0);
    chk({tag, "_static"}, int'(phase_static),  0);
    chk({tag, "_highz"},  int'(phase_high_z),  0);
  endtask

  initial begin
    int s0;

    // hi, g1, lo, g2, nper, shoot_at, clr, strobes, duty, period, dmin, fdead, fshoot
    vecs[0] = '{510, 2, 509, 2, 4,  -1, 1'b0, 3, 510, 1023, 2, 0, 0};  // arming edge then 3 strobes
    vecs[1] = '{510, 1, 510, 2, 3,  -1, 1'b0, 3, 510, 1023, 1, 1, 0};  // low-side 1 cycle early
    vecs[2] = '{510, 2, 509, 2, 3,  -1, 1'b1, 3, 510, 1023, 2, 0, 0};  // clear, gaps back to 2
    vecs[3] = '{510, 2, 509, 2, 3, 100, 1'b0, 2, 510, 1023, 2, 0, 1};  // shoot-through in period 0
    vecs[4] = '{510, 2, 509, 2, 2,  -1, 1'b1, 2, 510, 1023, 2, 0, 0};  // clear shoot fault

    pwm_high    = 1'b0;
    pwm_low     = 1'b0;
    clear_fault = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk_reset_values("por");

    for (int v = 0; v < 5; v++) begin
      s0          = n_strobes;
      clear_fault = vecs[v].clr;
      for (int p = 0; p < vecs[v].nper; p++)
        run_period(vecs[v].hi, vecs[v].g1, vecs[v].lo, vecs[v].g2, (p == 0) ? vecs[v].shoot_at : -1);
      chk($sformatf("v%0d_strobes", v), n_strobes - s0,        vecs[v].exp_strobes);
      chk($sformatf("v%0d_duty", v),    last_duty,             vecs[v].exp_duty);
      chk($sformatf("v%0d_period", v),  last_period,           vecs[v].exp_period);
      chk($sformatf("v%0d_dmin", v),    int'(dead_time_min),   vecs[v].exp_dmin);
      chk($sformatf("v%0d_fdead", v),   int'(fault_dead),      vecs[v].exp_fdead);
      chk($sformatf("v%0d_fshoot", v),  int'(fault_shoot),     vecs[v].exp_fshoot);
    end

    // Low side held on: single timeout strobe reporting a static-low phase
    s0 = n_strobes;
    for (int i = 0; i < 3000; i++) cyc(1'b0, 1'b1);
    chk("lowhold_strobes", n_strobes - s0,      1);
    chk("lowhold_duty",    last_duty,           0);
    chk("lowhold_period",  last_period,         1023);
    chk("lowhold_static",  int'(phase_static),  1);
    chk("lowhold_highz",   int'(phase_high_z),  0);
    chk("lowhold_fdead",   int'(fault_dead),    0);

    // Both gates off: timer already expired, so no further strobe
    s0 = n_strobes;
    for (int i = 0; i < 3000; i++) cyc(1'b0, 1'b0);
    chk("hiz_strobes", n_strobes - s0,     0);
    chk("hiz_static",  int'(phase_static), 1);
    chk("hiz_highz",   int'(phase_high_z), 1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    chk("hiz_pulse_static", int'(phase_static), 0);
    chk("hiz_pulse_highz",  int'(phase_high_z), 0);

    // Reset in the middle of a period
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++)   cyc(1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    chk_reset_values("mid_rst");
    s0 = n_strobes;
    for (int p = 0; p < 3; p++) run_period(510, 2, 509, 2, -1);
    chk("post_rst_strobes", n_strobes - s0,     2);
    chk("post_rst_duty",    last_duty,          510);
    chk("post_rst_period",  last_period,        1023);
    chk("post_rst_dmin",    int'(dead_time_min), 2);
    chk("post_rst_faults",  int'({fault_shoot, fault_dead}), 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
